// File: rtl/ram_init_pkg.sv
// rtl/ram_init_pkg.sv - shared constants and state type for the RAM init sequencer
package ram_init_pkg;

    localparam int RAM_INIT_ZERO = 0;
    localparam int RAM_INIT_SEQ  = 1;

    typedef enum logic [1:0] {
        RST   = 2'd0,
        INIT  = 2'd1,
        READY = 2'd2
    } init_state_t;

endpackage

// File: rtl/ram_init_addr_gen.sv
// rtl/ram_init_addr_gen.sv - init walk address counter that skips gated partitions
module ram_init_addr_gen #(
    parameter int DEPTH         = 128,
    parameter int INDEX         = 7,
    parameter int NUM_PARTS     = 4,
    parameter int NUM_PARTS_LOG = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load,
    input  logic                 advance,
    input  logic [NUM_PARTS-1:0] mask,
    output logic [INDEX-1:0]     addr,
    output logic                 last,
    output logic                 none_active
);

    localparam int PART_BITS = $clog2(DEPTH / NUM_PARTS);

    logic [INDEX-1:0]         cnt;
    logic [NUM_PARTS-1:0]     gated_q;
    logic [NUM_PARTS_LOG-1:0] cur_part;
    logic [NUM_PARTS_LOG-1:0] next_part;
    logic [NUM_PARTS_LOG-1:0] first_part;
    logic                     next_found;

    assign cur_part = cnt[INDEX-1:PART_BITS];

    // Descending scan so the lowest qualifying partition wins.
    always_comb begin
        next_found = 1'b0;
        next_part  = '0;
        first_part = '0;
        for (int p = NUM_PARTS - 1; p >= 0; p--) begin
            if (!gated_q[p] && (NUM_PARTS_LOG'(p) > cur_part)) begin
                next_found = 1'b1;
                next_part  = NUM_PARTS_LOG'(p);
            end
            if (!mask[p]) begin
                first_part = NUM_PARTS_LOG'(p);
            end
        end
    end

    assign last        = (&cnt[PART_BITS-1:0]) && !next_found;
    assign none_active = &gated_q;
    assign addr        = cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt     <= '0;
            gated_q <= '0;
        end else if (load) begin
            gated_q <= mask;
            cnt     <= {first_part, PART_BITS'(0)};
        end else if (advance && !last) begin
            if (&cnt[PART_BITS-1:0]) begin
                cnt <= {next_part, PART_BITS'(0)};
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/ram_init_sequencer.sv
// rtl/ram_init_sequencer.sv - RAM write port 0 initialiser with functional write pass-through
module ram_init_sequencer
    import ram_init_pkg::*;
#(
    parameter int DEPTH         = 128,
    parameter int INDEX         = 7,
    parameter int WIDTH         = 8,
    parameter int NUM_PARTS     = 4,
    parameter int NUM_PARTS_LOG = 2,
    parameter int RESET_MODE    = RAM_INIT_ZERO,
    parameter int SEQ_START     = 34
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_PARTS-1:0] partitionGated_i,
    input  logic                 reinit_i,
    input  logic                 wrEn_i,
    input  logic [INDEX-1:0]     addrWr_i,
    input  logic [WIDTH-1:0]     dataWr_i,
    output logic                 wrEn_o,
    output logic [INDEX-1:0]     addrWr_o,
    output logic [WIDTH-1:0]     dataWr_o,
    output logic                 ready_o,
    output logic                 busy_o,
    output logic                 wrDropped_o
);

    init_state_t      state;
    init_state_t      state_nxt;
    logic [INDEX-1:0] cnt;
    logic             last;
    logic             none_active;
    logic             load;
    logic             advance;
    logic [WIDTH-1:0] init_data;

    // Mask is relatched on every walk start: leaving RST or any reinit request.
    assign load    = (state == RST) || reinit_i;
    assign advance = (state == INIT) && !reinit_i;

    ram_init_addr_gen #(
        .DEPTH         (DEPTH),
        .INDEX         (INDEX),
        .NUM_PARTS     (NUM_PARTS),
        .NUM_PARTS_LOG (NUM_PARTS_LOG)
    ) u_addr_gen (
        .clk         (clk),
        .reset       (reset),
        .load        (load),
        .advance     (advance),
        .mask        (partitionGated_i),
        .addr        (cnt),
        .last        (last),
        .none_active (none_active)
    );

    assign init_data = (RESET_MODE == RAM_INIT_SEQ) ? WIDTH'(SEQ_START + int'(cnt)) : '0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= RST;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            RST:     state_nxt = INIT;
            INIT: begin
                if (!reinit_i && (none_active || last)) begin
                    state_nxt = READY;
                end
            end
            READY: begin
                if (reinit_i) begin
                    state_nxt = INIT;
                end
            end
            default: state_nxt = RST;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wrEn_o      <= 1'b0;
            addrWr_o    <= '0;
            dataWr_o    <= '0;
            ready_o     <= 1'b0;
            busy_o      <= 1'b0;
            wrDropped_o <= 1'b0;
        end else begin
            wrDropped_o <= wrEn_i && ((state != READY) || reinit_i);
            case (state)
                INIT: begin
                    // The edge that restarts the walk emits no write.
                    wrEn_o   <= !reinit_i && !none_active;
                    addrWr_o <= cnt;
                    dataWr_o <= init_data;
                    ready_o  <= 1'b0;
                    busy_o   <= 1'b1;
                end
                READY: begin
                    busy_o <= 1'b0;
                    if (reinit_i) begin
                        wrEn_o   <= 1'b0;
                        addrWr_o <= '0;
                        dataWr_o <= '0;
                        ready_o  <= 1'b0;
                    end else begin
                        wrEn_o   <= wrEn_i;
                        addrWr_o <= addrWr_i;
                        dataWr_o <= dataWr_i;
                        ready_o  <= 1'b1;
                    end
                end
                default: begin
                    wrEn_o   <= 1'b0;
                    addrWr_o <= '0;
                    dataWr_o <= '0;
                    ready_o  <= 1'b0;
                    busy_o   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_init_sequencer.sv
// tb/tb_ram_init_sequencer.sv - self-checking bench for ram_init_sequencer
module tb_ram_init_sequencer;
    import ram_init_pkg::*;

    logic       clk     = 1'b0;
    logic       reset   = 1'b1;
    logic [3:0] gated   = 4'b0000;
    logic       reinit  = 1'b0;
    logic       wr_en   = 1'b0;
    logic [6:0] addr_in = '0;
    logic [7:0] data_in = '0;

    logic       we_z, we_a, we_b;
    logic [6:0] ad_z, ad_a, ad_b;
    logic [7:0] d_z, d_a, d_b;
    logic       rdy_z, rdy_a, rdy_b;
    logic       busy_z, busy_a, busy_b;
    logic       drop_z, drop_a, drop_b;

    int checks = 0;
    int errors = 0;
    int exp_q[$];

    always #5 clk = ~clk;

    ram_init_sequencer #(.RESET_MODE(RAM_INIT_ZERO), .SEQ_START(34)) dut_z (
        .clk(clk), .reset(reset), .partitionGated_i(gated), .reinit_i(reinit),
        .wrEn_i(wr_en), .addrWr_i(addr_in), .dataWr_i(data_in),
        .wrEn_o(we_z), .addrWr_o(ad_z), .dataWr_o(d_z),
        .ready_o(rdy_z), .busy_o(busy_z), .wrDropped_o(drop_z));

    ram_init_sequencer #(.RESET_MODE(RAM_INIT_SEQ), .SEQ_START(34)) dut_a (
        .clk(clk), .reset(reset), .partitionGated_i(gated), .reinit_i(reinit),
        .wrEn_i(wr_en), .addrWr_i(addr_in), .dataWr_i(data_in),
        .wrEn_o(we_a), .addrWr_o(ad_a), .dataWr_o(d_a),
        .ready_o(rdy_a), .busy_o(busy_a), .wrDropped_o(drop_a));

    ram_init_sequencer #(.RESET_MODE(RAM_INIT_SEQ), .SEQ_START(200)) dut_b (
        .clk(clk), .reset(reset), .partitionGated_i(gated), .reinit_i(reinit),
        .wrEn_i(wr_en), .addrWr_i(addr_in), .dataWr_i(data_in),
        .wrEn_o(we_b), .addrWr_o(ad_b), .dataWr_o(d_b),
        .ready_o(rdy_b), .busy_o(busy_b), .wrDropped_o(drop_b));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] seq_val(input int start, input int a);
        return 8'((start + a) % 256);
    endfunction

    // Every ungated 32-entry partition in ascending order, nothing else.
    task automatic build(input logic [3:0] mask);
        exp_q.delete();
        for (int a = 0; a < 128; a++) begin
            if (!mask[a / 32]) exp_q.push_back(a);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_we"}, we_z, 0);
        chk({tag, "_addr"}, ad_z, 0);
        chk({tag, "_data"}, d_z, 0);
        chk({tag, "_ready"}, rdy_z, 0);
        chk({tag, "_busy"}, busy_z, 0);
        chk({tag, "_drop"}, drop_z, 0);
        chk({tag, "_we_seq"}, {we_a, we_b}, 0);
        chk({tag, "_data_seq"}, {d_a, d_b}, 0);
        chk({tag, "_ready_seq"}, {rdy_a, rdy_b, busy_a, busy_b, drop_a, drop_b}, 0);
    endtask

    // Holds reset, checks the reset values, releases it and stops just after the first edge.
    task automatic start(input logic [3:0] mask);
        reset = 1'b0;
        gated = mask;
        @(negedge clk);
        chk_zero("reset");
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
    endtask

    // Called at the negedge following the edge that loaded the mask.
    task automatic walk(input logic [3:0] mask, input int drop_at, input int stop_at);
        int n;
        build(mask);
        n = exp_q.size();
        chk("load_we", we_z, 0);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk("walk_we", {we_z, we_a, we_b}, 3'b111);
            chk("walk_addr_z", ad_z, exp_q[i]);
            chk("walk_addr_seq", {ad_a, ad_b}, {7'(exp_q[i]), 7'(exp_q[i])});
            chk("walk_data_z", d_z, 0);
            chk("walk_data_s34", d_a, seq_val(34, exp_q[i]));
            chk("walk_data_s200", d_b, seq_val(200, exp_q[i]));
            chk("walk_busy", busy_z, 1);
            chk("walk_ready", rdy_z, 0);
            chk("walk_drop", drop_z, (drop_at >= 0) && (i == drop_at + 1));
            wr_en   = (i == drop_at);
            addr_in = 7'($urandom);
            data_in = 8'($urandom);
            if (i == stop_at) return;
        end
        if (n == 0) begin
            @(negedge clk);
            chk("gated_we", we_z, 0);
            chk("gated_ready", rdy_z, 0);
            chk("gated_busy", busy_z, 1);
        end
        @(negedge clk);
        chk("done_ready", {rdy_z, rdy_a, rdy_b}, 3'b111);
        chk("done_busy", busy_z, 0);
        chk("done_we", {we_z, we_a, we_b}, 0);
    endtask

    task automatic pass(input logic [6:0] a, input logic [7:0] d, input logic en);
        wr_en   = en;
        addr_in = a;
        data_in = d;
        @(negedge clk);
        wr_en = 1'b0;
        chk("pass_we", we_z, en);
        chk("pass_drop", drop_z, 0);
        chk("pass_ready", rdy_z, 1);
        if (en) begin
            chk("pass_addr", ad_z, a);
            chk("pass_data", d_z, d);
            chk("pass_data_seq", {d_a, d_b}, {d, d});
        end
    endtask

    initial begin
        logic [3:0] m;
        #2;

        // ZERO/SEQ walks with no gating, one write dropped mid-walk.
        start(4'b0000);
        walk(4'b0000, 10, -1);
        pass(7'd5, 8'h3C, 1'b1);
        for (int k = 0; k < 4; k++) pass(7'($urandom), 8'($urandom), 1'($urandom));
        pass(7'd0, 8'h00, 1'b0);

        // Reinit from READY with a functional write on the same edge.
        gated  = 4'b1110;
        reinit = 1'b1;
        wr_en  = 1'b1;
        @(negedge clk);
        reinit = 1'b0;
        wr_en  = 1'b0;
        chk("reinit_ready", rdy_z, 0);
        chk("reinit_drop", drop_z, 1);
        walk(4'b1110, -1, -1);

        // Reinit mid-walk at cnt=50 with a new mask.
        start(4'b0000);
        walk(4'b0000, -1, 49);
        gated  = 4'b1100;
        reinit = 1'b1;
        @(negedge clk);
        reinit = 1'b0;
        chk("midwalk_busy", busy_z, 1);
        walk(4'b1100, -1, -1);

        start(4'b0101);
        walk(4'b0101, 5, -1);

        start(4'b1111);
        walk(4'b1111, -1, -1);

        for (int k = 0; k < 3; k++) begin
            m = 4'($urandom);
            start(m);
            walk(m, -1, -1);
            m = 4'($urandom);
            gated  = m;
            reinit = 1'b1;
            @(negedge clk);
            reinit = 1'b0;
            walk(m, -1, -1);
        end

        // Asynchronous reset in the middle of a walk.
        start(4'b0000);
        walk(4'b0000, -1, 20);
        #2;
        reset = 1'b0;
        #1;
        chk_zero("async_reset");
        @(negedge clk);
        chk_zero("async_hold");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ram_init_sequencer.md
Name: ram_init_sequencer

Overview:
Write-side initialiser for RAM_CONFIGURABLE-style structures. After reset, or on request, it walks every active entry and writes the reset value on one write port: zero, or SEQ_START+address. While it runs it holds off functional writes, and it raises ready_o when the contents are valid. It replaces per-RAM internal init logic. Core write port 0 passes through this block.

Parameters:
DEPTH, 128, number of RAM entries
INDEX, 7, address width (log2 DEPTH)
WIDTH, 8, data width
NUM_PARTS, 4, equal-size partitions (DEPTH/NUM_PARTS entries each, power of 2)
NUM_PARTS_LOG, 2, log2 NUM_PARTS
RESET_MODE, RAM_INIT_ZERO, RAM_INIT_ZERO (0) or RAM_INIT_SEQ (1)
SEQ_START, 34, base value for RAM_INIT_SEQ

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low (0 = in reset)
partitionGated_i  in  NUM_PARTS  1 = partition powered down, skipped by init
reinit_i  in  1  single-cycle request to re-initialise (e.g. after partition reconfig)
wrEn_i  in  1  functional write enable
addrWr_i  in  INDEX  functional write address
dataWr_i  in  WIDTH  functional write data
wrEn_o  out  1  write enable to RAM port 0
addrWr_o  out  INDEX  write address to RAM port 0
dataWr_o  out  WIDTH  write data to RAM port 0
ready_o  out  1  RAM contents valid, functional writes accepted
busy_o  out  1  init walk in progress
wrDropped_o  out  1  pulse: functional write arrived while not ready, discarded

Behaviour:
- States: RST, INIT, READY.
- Reset asserted, async: state=RST, addr counter=0, ready_o=0, busy_o=0, wrEn_o=0, addrWr_o=0, dataWr_o=0, wrDropped_o=0.
- RST -> INIT on the first clk edge after reset deasserts. partitionGated_i is latched into gatedQ at INIT entry. Later changes are ignored until the next INIT entry.
- INIT: one registered write per cycle.
  - wrEn_o=1; addrWr_o=cnt.
  - dataWr_o=0 in ZERO mode, (SEQ_START+cnt) truncated to WIDTH in SEQ mode.
  - busy_o=1.
- Address generation:
  - cnt starts at the first ungated partition base.
  - After the last entry of a partition, cnt jumps to the base of the next ungated partition.
  - After the last ungated entry, next state is READY.
  - No wrap past DEPTH-1.
- All partitions gated: INIT lasts exactly 1 cycle with wrEn_o=0, then READY.
- Latency, no gating: reset release at edge E0. Writes at addresses 0..DEPTH-1 appear after edges E1..E128. ready_o=1 after E129.
- READY: ready_o=1, busy_o=0. Outputs are a registered pass-through of wrEn_i/addrWr_i/dataWr_i, 1-cycle latency.
- Not READY (RST or INIT): wrEn_i is discarded. wrDropped_o=1 in the following cycle for each dropped write.
- reinit_i in READY: next state INIT, gated mask relatched, cnt restarts. ready_o drops on the same edge. A functional write sampled on that edge is dropped and flagged.
- reinit_i during INIT: walk restarts from the first ungated base, and the mask is relatched.
- reset asserted mid-INIT: immediate return to RST values.

Decomposition:
- Package ram_init_pkg holds:
  - RAM_INIT_ZERO and RAM_INIT_SEQ constants
  - state enum typedef init_state_t {RST, INIT, READY}
- Sub-module ram_init_addr_gen holds the cnt register plus next-ungated-partition lookup, a priority search over gatedQ. Outputs: addr, last, none_active.

Test Plan:
- ZERO mode, no gating, DEPTH=128 -> 128 consecutive writes, addr 0..127, data 0. ready_o rises on cycle 129 after reset release. No gaps.
- SEQ mode, SEQ_START=34, WIDTH=8 -> data at addr 0 = 0x22, addr 127 = 0xA1. With SEQ_START=200, addr 100 writes 0x2C (truncation).
- partitionGated_i=4'b1110 -> writes only at addr 0..31, READY after 32 writes. 4'b0101 -> addr 32..63 then 96..127, 64 writes.
- partitionGated_i=4'b1111 -> no write, ready_o=1 two edges after reset release.
- wrEn_i pulsed during INIT -> wrDropped_o=1 next cycle, RAM write absent. After READY, write addr 5 data 0x3C appears on outputs 1 cycle later.
- reinit_i mid-walk at cnt=50, mask changed to 4'b1100 -> walk restarts at 0, covers 0..63, then READY. Reset pulse mid-INIT -> all outputs 0 immediately.
